// File: rtl/wb_arbiter.sv
// wb_arbiter: merges two pipe results and a long-latency FIFO onto a dual-port regfile write.
// Define WB_BYPASS_EN to let an lr result skip an empty FIFO and write one cycle after acceptance.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        p0_valid,
  input  logic [4:0]  p0_waddr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_valid,
  input  logic [4:0]  p1_waddr,
  input  logic [31:0] p1_wdata,
  input  logic        lr_valid,
  input  logic [4:0]  lr_waddr,
  input  logic [31:0] lr_wdata,
  output logic        lr_ready,
  output logic        we1,
  output logic [4:0]  waddr1,
  output logic [31:0] wdata1,
  output logic        we2,
  output logic [4:0]  waddr2,
  output logic [31:0] wdata2,
  output logic [31:0] pend_mask
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [4:0]    ent_a [DEPTH];
  logic [31:0]   ent_d [DEPTH];
  logic [CW-1:0] cnt;
  logic [4:0]    nxt_a [DEPTH];
  logic [31:0]   nxt_d [DEPTH];
  logic [CW-1:0] nxt_cnt;
  logic [DEPTH-1:0] live;
  logic          pv0, pv1, lr_live, byp, enq;
  logic [1:0]    nd;
  logic [4:0]    s_v;
  logic [4:0]    s_a [5];
  logic [31:0]   s_d [5];
  logic          n_we1, n_we2;
  logic [4:0]    n_a1, n_a2;
  logic [31:0]   n_d1, n_d2;
  assign lr_ready = aresetn && (cnt < CW'(DEPTH));
  assign pv0 = p0_valid && |p0_waddr;
  assign pv1 = p1_valid && |p1_waddr;
  assign nd = (pv0 && pv1) ? 2'd0 : (pv0 || pv1) ? 2'd1 : 2'd2;
  assign lr_live = lr_valid && lr_ready && |lr_waddr &&
                   !((pv0 && lr_waddr == p0_waddr) || (pv1 && lr_waddr == p1_waddr));
`ifdef WB_BYPASS_EN
  assign byp = lr_live && !(|live) && !(pv0 && pv1);
`else
  assign byp = 1'b0;
`endif
  assign enq = lr_live && !byp;
  // an entry is live unless a same-cycle pipe write to its register supersedes it
  always_comb begin
    for (int k = 0; k < DEPTH; k++)
      live[k] = (CW'(k) < cnt) &&
                !((pv0 && ent_a[k] == p0_waddr) || (pv1 && ent_a[k] == p1_waddr));
  end
  // the queue is kept compacted oldest-first: drained and squashed entries close up
  always_comb begin
    int j;
    int m;
    j = 0;
    m = 0;
    nxt_a = ent_a;
    nxt_d = ent_d;
    s_v = '0;
    s_a = '{default: '0};
    s_d = '{default: '0};
    for (int k = 0; k < DEPTH; k++) begin
      if (live[k]) begin
        if (m < int'(nd)) begin
          s_v[m[0]] = 1'b1;
          s_a[m[0]] = ent_a[k];
          s_d[m[0]] = ent_d[k];
        end else begin
          nxt_a[j[AW-1:0]] = ent_a[k];
          nxt_d[j[AW-1:0]] = ent_d[k];
          j++;
        end
        m++;
      end
    end
    if (enq) begin
      nxt_a[j[AW-1:0]] = lr_waddr;
      nxt_d[j[AW-1:0]] = lr_wdata;
    end
    nxt_cnt = CW'(j) + CW'(enq);
    s_v[2] = byp;
    s_a[2] = lr_waddr;
    s_d[2] = lr_wdata;
    s_v[3] = pv0;
    s_a[3] = p0_waddr;
    s_d[3] = p0_wdata;
    s_v[4] = pv1;
    s_a[4] = p1_waddr;
    s_d[4] = p1_wdata;
  end
  // sources are listed oldest-first, so the first taken goes to port1
  always_comb begin
    n_we1 = 1'b0;
    n_a1 = '0;
    n_d1 = '0;
    n_we2 = 1'b0;
    n_a2 = '0;
    n_d2 = '0;
    for (int k = 0; k < 5; k++) begin
      if (s_v[k] && !n_we1) begin
        n_we1 = 1'b1;
        n_a1 = s_a[k];
        n_d1 = s_d[k];
      end else if (s_v[k] && !n_we2) begin
        n_we2 = 1'b1;
        n_a2 = s_a[k];
        n_d2 = s_d[k];
      end
    end
  end
  always_comb begin
    pend_mask = '0;
    for (int k = 0; k < DEPTH; k++)
      if (CW'(k) < cnt) pend_mask[ent_a[k]] = 1'b1;
  end
  always_ff @(posedge clk) begin
    ent_a <= nxt_a;
    ent_d <= nxt_d;
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
      we1 <= 1'b0;
      waddr1 <= '0;
      wdata1 <= '0;
      we2 <= 1'b0;
      waddr2 <= '0;
      wdata2 <= '0;
    end else begin
      cnt <= nxt_cnt;
      we1 <= n_we1;
      waddr1 <= n_a1;
      wdata1 <= n_d1;
      we2 <= n_we2;
      waddr2 <= n_a2;
      wdata2 <= n_d2;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  logic clk = 0, aresetn = 0;
  logic p0_valid = 0, p1_valid = 0, lr_valid = 0;
  logic [4:0] p0_waddr = 0, p1_waddr = 0, lr_waddr = 0;
  logic [31:0] p0_wdata = 0, p1_wdata = 0, lr_wdata = 0;
  logic lr_ready, we1, we2;
  logic [4:0] waddr1, waddr2;
  logic [31:0] wdata1, wdata2, pend_mask;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .aresetn(aresetn),
    .p0_valid(p0_valid), .p0_waddr(p0_waddr), .p0_wdata(p0_wdata),
    .p1_valid(p1_valid), .p1_waddr(p1_waddr), .p1_wdata(p1_wdata),
    .lr_valid(lr_valid), .lr_waddr(lr_waddr), .lr_wdata(lr_wdata),
    .lr_ready(lr_ready),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
    .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
  typedef struct packed {
    logic we1; logic [4:0] a1; logic [31:0] d1;
    logic we2; logic [4:0] a2; logic [31:0] d2;
    logic rdy; logic [31:0] pm;
  } exp_t;

  wr_t  mq[$];
  exp_t eq[$];
  int n_pass = 0, n_chk = 0;
  bit mon_en = 0, acc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (mon_en) begin
      exp_t e;
      #1;
      check("exp_avail", 32'(eq.size() != 0), 32'd1);
      if (eq.size() != 0) begin
        e = eq.pop_front();
        check("we1", 32'(we1), 32'(e.we1));
        if (e.we1) begin
          check("waddr1", 32'(waddr1), 32'(e.a1));
          check("wdata1", wdata1, e.d1);
        end
        check("we2", 32'(we2), 32'(e.we2));
        if (e.we2) begin
          check("waddr2", 32'(waddr2), 32'(e.a2));
          check("wdata2", wdata2, e.d2);
        end
        check("lr_ready", 32'(lr_ready), 32'(e.rdy));
        check("pend_mask", pend_mask, e.pm);
      end
    end
  end

  // Reference: queue of pending lr writes, oldest first; squash deletes, drain pops front.
  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    wr_t w[$];
    exp_t e;
    bit pv0, pv1, rdy, live, empty;
    p0_valid = v0; p0_waddr = a0; p0_wdata = d0;
    p1_valid = v1; p1_waddr = a1; p1_wdata = d1;
    lr_valid = lv; lr_waddr = la; lr_wdata = ld;
    rdy = mq.size() < DEPTH;
    acc = lv && rdy;
    pv0 = v0 && a0 != 0;
    pv1 = v1 && a1 != 0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if ((pv0 && mq[i].a == a0) || (pv1 && mq[i].a == a1)) mq.delete(i);
    empty = mq.size() == 0;
    if (pv0 && pv1) begin
      w.push_back({a0, d0});
      w.push_back({a1, d1});
    end else begin
      for (int n = (pv0 || pv1) ? 1 : 2; n > 0 && mq.size() > 0; n--) w.push_back(mq.pop_front());
    end
    live = acc && la != 0 && !((pv0 && la == a0) || (pv1 && la == a1));
`ifdef WB_BYPASS_EN
    if (live && empty && !(pv0 && pv1)) begin
      w.push_back({la, ld});
      live = 0;
    end
`endif
    if (live) mq.push_back({la, ld});
    if (!(pv0 && pv1)) begin
      if (pv0) w.push_back({a0, d0});
      if (pv1) w.push_back({a1, d1});
    end
    e = '0;
    if (w.size() > 0) begin e.we1 = 1; e.a1 = w[0].a; e.d1 = w[0].d; end
    if (w.size() > 1) begin e.we2 = 1; e.a2 = w[1].a; e.d2 = w[1].d; end
    e.rdy = mq.size() < DEPTH;
    foreach (mq[i]) e.pm[mq[i].a] = 1'b1;
    eq.push_back(e);
  endtask

  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld);
    @(negedge clk);
    drive(v0, a0, d0, v1, a1, d1, lv, la, ld);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_we1"}, 32'(we1), 0);
    check({tag, "_we2"}, 32'(we2), 0);
    check({tag, "_waddr1"}, 32'(waddr1), 0);
    check({tag, "_wdata1"}, wdata1, 0);
    check({tag, "_waddr2"}, 32'(waddr2), 0);
    check({tag, "_wdata2"}, wdata2, 0);
    check({tag, "_lr_ready"}, 32'(lr_ready), 0);
    check({tag, "_pend_mask"}, pend_mask, 0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    aresetn = 1;
    #1;
    check("lr_ready_after_release", 32'(lr_ready), 1);
    mon_en = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2;
    mon_en = 0;
    @(negedge clk);
    aresetn = 0;
    p0_valid = 0; p1_valid = 0; lr_valid = 0;
    #1;
    reset_checks("mid_reset");
    mq.delete();
    eq.delete();
    repeat (2) @(negedge clk);
    release_rst();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout after %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bit hold;
    logic lv, v0, v1;
    logic [4:0] la, a0, a1;
    logic [31:0] ld;
    int k;
    hold = 0; lv = 0; la = 0; ld = 0;
    repeat (2) @(negedge clk);
    #1;
    reset_checks("reset");
    release_rst();
    // same-cycle pipe pair to one register
    step(1, 3, 32'h11, 1, 3, 32'h22, 0, 0, 0);
    idle(2);
    // lone lr result, idle pipes
    step(0, 0, 0, 0, 0, 0, 1, 5, 32'hAA);
    idle(3);
    // queue r7, r8 behind busy pipes, then release
    step(1, 1, 32'h1, 1, 2, 32'h2, 1, 7, 32'h77);
    step(1, 1, 32'h3, 1, 2, 32'h4, 1, 8, 32'h88);
    idle(3);
    // queued r9 superseded by younger p0 write
    step(1, 1, 32'h5, 1, 2, 32'h6, 1, 9, 32'h5);
    step(1, 9, 32'h6, 0, 0, 0, 0, 0, 0);
    idle(3);
    // zero-address writes are dropped; lr to r0 still handshakes
    step(1, 0, 32'hDEAD, 1, 4, 32'h44, 1, 0, 32'hBEEF);
    idle(2);
    // fill, stall, drain over several rounds
    for (int r = 0; r < 3; r++) begin
      k = 0;
      for (int c = 0; c < 6; c++) begin
        step(1, 1, 32'(r), 1, 2, 32'(c), 1, 5'(10 + k), 32'h100 * r + 32'(k));
        if (acc) k++;
      end
      for (int c = 0; c < 3; c++) begin
        step(0, 0, 0, 0, 0, 0, k < 5, 5'(10 + k), 32'h100 * r + 32'(k));
        if (acc) k++;
      end
      idle(2);
    end
    // reset with queued entries
    for (int c = 0; c < 3; c++) step(1, 1, 0, 1, 2, 0, 1, 5'(20 + c), 32'(c));
    mid_reset();
    idle(4);
    // randomized traffic over a small register window to force conflicts
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        lv = $urandom_range(0, 2) != 0;
        la = 5'($urandom_range(0, 7));
        ld = $urandom;
      end
      v0 = $urandom_range(0, 2) != 0;
      v1 = $urandom_range(0, 2) != 0;
      a0 = 5'($urandom_range(0, 7));
      a1 = 5'($urandom_range(0, 7));
      step(v0, a0, $urandom, v1, a1, $urandom, lv, la, ld);
      hold = lv && !acc;
    end
    idle(6);
    @(posedge clk);
    #2;
    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
